memory_unit: RTL

MEMORY_UNIT -- requirements
Module: memory_unit

---
 rtl/memory_unit_pkg.sv | 42 ++++
 rtl/memory_unit_pipeline.sv | 50 +++++
 rtl/memory_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/memory_unit_pkg.sv
// ============================================================================
// memory_unit_pkg : shared CPU definitions for the memory stage
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package memory_unit_pkg;

    localparam logic [31:0] NOP = 32'hF000_0000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_MEM  = 2'd1,
        CLS_BR   = 2'd2,
        CLS_NONE = 2'd3
    } op_class_e;

    function automatic op_class_e op_class(input logic [6:0] opcode);
        op_class_e cls;
        cls = CLS_NONE;
        if (opcode[6:5] == 2'b11 || opcode[6:3] == 4'b1000) begin
            cls = CLS_MEM;
        end else if (opcode[6:3] == 4'b1001) begin
            cls = CLS_BR;
        end else if (!opcode[6] && opcode[5:4] != 2'b10) begin
            cls = CLS_ALU;
        end
        return cls;
    endfunction

    function automatic logic is_bubble(input logic [31:0] instr);
        return instr[31:28] == 4'hF;
    endfunction

endpackage

`default_nettype wire

// File: rtl/memory_unit_pipeline.sv
// ============================================================================
// pipeline_unit : instruction and epoch register between execute and memory
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module pipeline_unit
    import memory_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel_stall,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic        branch_in,
    output logic [31:0] instr_out,
    output logic        branch_out
);

    logic [31:0] instr_q, instr_d;
    logic        branch_q, branch_d;

    // A flush overrides the stall but keeps the epoch of the dropped instruction
    always_comb begin
        instr_d  = instr_q;
        branch_d = branch_q;
        if (flush) begin
            instr_d = NOP;
        end else if (!sel_stall) begin
            instr_d  = instr_in;
            branch_d = branch_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= NOP;
            branch_q <= 1'b0;
        end else begin
            instr_q  <= instr_d;
            branch_q <= branch_d;
        end
    end

    assign instr_out  = instr_q;
    assign branch_out = branch_q;

endmodule

`default_nettype wire

// File: rtl/memory_unit.sv
// ============================================================================
// memory_unit : memory pipeline stage with data-memory handshake and stall
// Optional watchdog compiled in with MEM_TIMEOUT_EN (adds mem_err port)
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module memory_unit
    import memory_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_in,
    input  logic        branch_ref,
    input  logic        branch_in,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  rd,
    output logic        rd_valid,
    output logic        sel_load,
    output logic        stall,
    output logic [31:0] instr_output,
    output logic        branch_value
`ifdef MEM_TIMEOUT_EN
   ,output logic        mem_err
`endif
);

    mem_state_e  state_q, state_d;
    logic [31:0] w_instr_next;
    logic [31:0] w_held;
    logic        w_next_mem;
    logic        w_timeout;
    logic        w_in_wait;
    op_class_e   w_held_cls;
    logic        w_held_bubble;
    logic        w_held_load;

    assign w_instr_next = (branch_in != branch_ref) ? NOP : instr_in;
    assign w_next_mem   = (op_class(w_instr_next[27:21]) == CLS_MEM) && !is_bubble(w_instr_next);
    assign w_in_wait    = (state_q == ST_WAIT);

`ifdef MEM_TIMEOUT_EN
    logic [3:0] cnt_q, cnt_d;

    assign w_timeout = w_in_wait && !mem_ready && (cnt_q == 4'd15);
    assign mem_err   = w_timeout;

    always_comb begin
        cnt_d = cnt_q;
        if (!stall && w_next_mem) begin
            cnt_d = 4'd0;
        end else if (w_in_wait && !mem_ready) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    pipeline_unit u_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_stall  (stall),
        .flush      (w_timeout),
        .instr_in   (w_instr_next),
        .branch_in  (branch_in),
        .instr_out  (w_held),
        .branch_out (branch_value)
    );

    // Every capture edge re-decides the state, so back-to-back accesses stay in WAIT
    always_comb begin
        state_d = state_q;
        if (w_timeout) begin
            state_d = ST_IDLE;
        end else if (!stall) begin
            state_d = w_next_mem ? ST_WAIT : ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign w_held_cls    = op_class(w_held[27:21]);
    assign w_held_bubble = is_bubble(w_held);
    assign w_held_load   = w_held[23];

    always_comb begin
        mem_req  = w_in_wait;
        mem_wr   = w_in_wait && !w_held_load;
        stall    = w_in_wait && !mem_ready;
        rd       = w_held_bubble ? 4'hF : w_held[15:12];
        rd_valid = 1'b0;
        sel_load = 1'b0;
        if (!w_held_bubble) begin
            if (w_held_cls == CLS_ALU) begin
                rd_valid = 1'b1;
            end else if (w_held_cls == CLS_MEM && w_held_load) begin
                sel_load = 1'b1;
                rd_valid = w_in_wait && mem_ready;
            end
        end
    end

    assign instr_output = w_held;

endmodule

`default_nettype wire
